// File: rtl/oets_stream_sorter.sv
// -----------------------------------------------------------------------------
// oets_stream_sorter
//
// Fully pipelined odd-even transposition sorter. Each vector carries M unsigned
// N-bit keys and a direction bit; it leaves the pipeline fully sorted M register
// stages after it was accepted. A single global enable advances or holds every
// stage, so a stalled consumer freezes the whole pipeline in place.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears all stage state)
//   in_valid   producer presents a vector on in_data / in_desc
//   in_ready   sorter accepts a vector this cycle (combinational)
//   in_desc    direction for this vector: 0 = ascending, 1 = descending
//   in_data    M lanes of N bits; lane i at bits [i*N +: N], lane 0 at LSBs
//   out_valid  out_data holds a sorted vector
//   out_ready  consumer takes out_data this cycle
//   out_desc   direction tag travelling with the vector
//   out_data   sorted vector, same lane packing as in_data
// -----------------------------------------------------------------------------
module oets_stream_sorter #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_desc,
    input  logic [M*N-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_desc,
    output logic [M*N-1:0] out_data
);

    // Stage registers: index k is pipeline stage Sk.
    logic           vld_p  [M];
    logic           desc_p [M];
    logic [M*N-1:0] data_p [M];

    logic en;

    // One compare-exchange layer. Even layers pair lanes (0,1),(2,3),...;
    // odd layers pair (1,2),(3,4),... leaving lanes 0 and M-1 untouched.
    // Pairs within a layer are disjoint, so reading from d and writing into r
    // never sees a partially exchanged value. Equal keys are never swapped.
    function automatic logic [M*N-1:0] cmp_exchange(
        input logic [M*N-1:0] d,
        input logic           odd,
        input logic           desc
    );
        logic [M*N-1:0] r;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic           swap;
        r = d;
        for (int j = 0; j < M - 1; j++) begin
            if (j[0] == odd) begin
                a    = d[j*N +: N];
                b    = d[(j+1)*N +: N];
                swap = desc ? (a < b) : (a > b);
                if (swap) begin
                    r[j*N +: N]     = b;
                    r[(j+1)*N +: N] = a;
                end
            end
        end
        return r;
    endfunction

    // The pipeline may move whenever the output slot is free or being drained;
    // this is the only path from out_ready back to the input side.
    assign en       = !vld_p[M-1] | out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < M; k++) begin
                vld_p[k]  <= 1'b0;
                desc_p[k] <= 1'b0;
                data_p[k] <= '0;
            end
        end else if (en) begin
            // S0: first (even) layer straight from the input port
            vld_p[0]  <= in_valid;
            desc_p[0] <= in_desc;
            data_p[0] <= cmp_exchange(in_data, 1'b0, in_desc);
            // S1..S(M-1): alternate odd/even layers, each using the direction
            // bit registered alongside its own data
            for (int k = 1; k < M; k++) begin
                vld_p[k]  <= vld_p[k-1];
                desc_p[k] <= desc_p[k-1];
                data_p[k] <= cmp_exchange(data_p[k-1], k[0], desc_p[k-1]);
            end
        end
    end

    assign out_valid = vld_p[M-1];
    assign out_desc  = desc_p[M-1];
    assign out_data  = data_p[M-1];

endmodule

// File: tb/tb_oets_stream_sorter.sv
module tb_oets_stream_sorter;

    typedef struct {
        logic [127:0] data;
        logic         desc;
        int           cyc;
        int           lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // dut0: M=4 N=8
    logic        iv0 = 1'b0, ids0 = 1'b0, or0 = 1'b1;
    logic [31:0] id0 = '0;
    logic        ir0, ov0, ods0;
    logic [31:0] od0;
    // dut1: M=2 N=1
    logic        iv1 = 1'b0, ids1 = 1'b0, or1 = 1'b1;
    logic [1:0]  id1 = '0;
    logic        ir1, ov1, ods1;
    logic [1:0]  od1;
    // dut2: M=8 N=16
    logic         iv2 = 1'b0, ids2 = 1'b0, or2 = 1'b1;
    logic [127:0] id2 = '0;
    logic         ir2, ov2, ods2;
    logic [127:0] od2;

    oets_stream_sorter #(.N(8), .M(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_desc(ids0),
        .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_desc(ods0), .out_data(od0)
    );
    oets_stream_sorter #(.N(1), .M(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_desc(ids1),
        .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_desc(ods1), .out_data(od1)
    );
    oets_stream_sorter #(.N(16), .M(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_desc(ids2),
        .in_data(id2), .out_valid(ov2), .out_ready(or2), .out_desc(ods2), .out_data(od2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Reference: unpack keys, sort with the queue methods, repack.
    function automatic logic [127:0] ref_sort(logic [127:0] v, int m, int n, bit ds);
        int unsigned  k[$];
        logic [127:0] mask;
        logic [127:0] r;
        mask = (128'd1 << n) - 128'd1;
        r = '0;
        for (int i = 0; i < m; i++) k.push_back(32'((v >> (i*n)) & mask));
        if (ds) k.rsort();
        else k.sort();
        for (int i = 0; i < m; i++) r = r | (128'(k[i]) << (i*n));
        return r;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    function automatic int qsize(int w);
        return (w == 0) ? q0.size() : (w == 1) ? q1.size() : q2.size();
    endfunction

    task automatic pop(int w, logic [127:0] d, logic ds);
        exp_t e;
        if (qsize(w) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output dut%0d: got %0h, required no output", w, d);
            return;
        end
        case (w)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("data_dut%0d", w), d, e.data);
        chk($sformatf("desc_dut%0d", w), 128'(ds), 128'(e.desc));
        if (e.lat >= 0) chk($sformatf("latency_dut%0d", w), 128'(cyc - e.cyc), 128'(e.lat));
    endtask

    // Present a vector at a falling edge, hold it until in_ready, then record
    // the expected result; acceptance happens at the following rising edge.
    task automatic send(int w, logic [127:0] d, bit ds, int lat, bit has_ex, logic [127:0] ex);
        exp_t e;
        int   tries;
        logic rdy;
        @(negedge clk);
        case (w)
            0:       begin iv0 = 1'b1; id0 = d[31:0]; ids0 = ds; end
            1:       begin iv1 = 1'b1; id1 = d[1:0];  ids1 = ds; end
            default: begin iv2 = 1'b1; id2 = d;       ids2 = ds; end
        endcase
        tries = 0;
        forever begin
            #1;
            rdy = (w == 0) ? ir0 : (w == 1) ? ir1 : ir2;
            if (rdy) break;
            tries++;
            if (tries > 50) begin
                total++;
                bad++;
                $display("FAIL accept_timeout dut%0d: in_ready stuck at 0, required 1", w);
                return;
            end
            @(negedge clk);
        end
        e.desc = ds;
        e.cyc  = cyc;
        e.lat  = lat;
        case (w)
            0:       begin e.data = has_ex ? ex : ref_sort(d, 4, 8, ds);  q0.push_back(e); end
            1:       begin e.data = has_ex ? ex : ref_sort(d, 2, 1, ds);  q1.push_back(e); end
            default: begin e.data = has_ex ? ex : ref_sort(d, 8, 16, ds); q2.push_back(e); end
        endcase
    endtask

    task automatic idle();
        @(negedge clk);
        iv0 = 1'b0;
        iv1 = 1'b0;
        iv2 = 1'b0;
    endtask

    task automatic drain(int w);
        int t;
        t = 0;
        while (qsize(w) != 0) begin
            @(negedge clk);
            t++;
            if (t > 100) begin
                total++;
                bad++;
                $display("FAIL drain_timeout dut%0d: %0d vectors outstanding, required 0", w, qsize(w));
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor dut0: also checks stall behaviour (in_ready low, output held).
    logic        held_v = 1'b0;
    logic [31:0] held_d = '0;
    logic        held_ds = 1'b0;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (ov0 && !or0) chk("stall_in_ready", 128'(ir0), 128'd0);
            if (held_v && ov0) begin
                chk("hold_data", 128'(od0), 128'(held_d));
                chk("hold_desc", 128'(ods0), 128'(held_ds));
            end
            held_v  = ov0 && !or0;
            held_d  = od0;
            held_ds = ods0;
            if (ov0 && or0) pop(0, 128'(od0), ods0);
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst && ov1 && or1) pop(1, 128'(od1), ods1);
    end

    always @(negedge clk) begin
        #2;
        if (!rst && ov2 && or2) pop(2, od2, ods2);
    end

    initial begin
        logic [127:0] v;
        logic [15:0]  key;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 128'(ov0), 128'd0);
        chk("reset_out_data", 128'(od0), 128'd0);
        chk("reset_out_desc", 128'(ods0), 128'd0);
        chk("reset_in_ready", 128'(ir0), 128'd1);
        chk("reset_out_valid_m8", 128'(ov2), 128'd0);
        repeat (3) @(negedge clk);

        // directed ascending / descending, empty pipeline, latency 4
        send(0, 128'h10FF1040, 1'b0, 4, 1'b1, 128'hFF401010);
        idle();
        drain(0);
        send(0, 128'h10FF1040, 1'b1, 4, 1'b1, 128'h101040FF);
        idle();
        drain(0);

        // back-to-back, alternating direction; no stall so every latency is 4
        for (int i = 0; i < 20; i++) send(0, 128'($urandom()), i[0], 4, 1'b0, '0);
        idle();
        drain(0);

        // backpressure: 3-cycle stall when the first vector reaches the output
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(0, 128'($urandom()), i[0], (i == 0) ? 7 : -1, 1'b0, '0);
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!ov0 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                or0 = 1'b0;
                repeat (3) @(negedge clk);
                or0 = 1'b1;
            end
        join
        idle();
        drain(0);

        // reset with three vectors in flight: none may ever appear
        for (int i = 0; i < 3; i++) send(0, 128'($urandom()), i[0], -1, 1'b0, '0);
        @(negedge clk);
        rst = 1'b1;
        iv0 = 1'b0;
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_out_valid", 128'(ov0), 128'd0);
        chk("midreset_out_data", 128'(od0), 128'd0);
        chk("midreset_in_ready", 128'(ir0), 128'd1);
        send(0, 128'h01020304, 1'b1, 4, 1'b1, 128'h01020304);
        idle();
        repeat (8) @(negedge clk);
        drain(0);

        // M=2, N=1: every key combination in both directions
        for (int p = 0; p < 4; p++)
            for (int ds = 0; ds < 2; ds++) send(1, 128'(p), ds[0], 2, 1'b0, '0);
        idle();
        drain(1);

        // M=8, N=16: boundary patterns in both directions, then random
        for (int p = 0; p < 5; p++) begin
            for (int ds = 0; ds < 2; ds++) begin
                v = '0;
                for (int i = 0; i < 8; i++) begin
                    case (p)
                        0:       key = 16'h1234;
                        1:       key = 16'(i * 4096 + i);
                        2:       key = 16'((7 - i) * 4096);
                        3:       key = 16'h0000;
                        default: key = 16'hFFFF;
                    endcase
                    v[i*16 +: 16] = key;
                end
                send(2, v, ds[0], 8, 1'b0, '0);
            end
        end
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 8; i++)
                v[i*16 +: 16] = r[0] ? 16'($urandom_range(0, 3) * 16'h5555) : 16'($urandom());
            send(2, v, r[1], 8, 1'b0, '0);
        end
        idle();
        drain(2);

        chk("leftover_dut0", 128'(q0.size()), 128'd0);
        chk("leftover_dut1", 128'(q1.size()), 128'd0);
        chk("leftover_dut2", 128'(q2.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oets_stream_sorter.md
Name: oets_stream_sorter

Overview:
- Parametrised, fully pipelined odd-even transposition sorter for M unsigned N-bit keys per vector.
- Successor to the fixed 4-lane, two-stage sorter: width, lane count and sort direction are selectable, and it adds valid/ready flow control and synchronous reset.
- Sits in the datapath between a vector producer and a consumer.
- Accepts one vector per clock when not stalled; emits each vector fully sorted after M register stages.

Parameters:
- N, 8, key width in bits (≥1).
- M, 4, lanes per vector; even, ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a vector on in_data.
- in_ready  output  1  sorter can accept a vector this cycle.
- in_desc  input  1  direction for this vector: 0 = ascending, 1 = descending.
- in_data  input  M*N  lane i occupies bits [i*N +: N]; lane 0 is at the LSBs.
- out_valid  output  1  out_data holds a sorted vector.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_desc  output  1  direction tag carried with the vector.
- out_data  output  M*N  sorted vector, same lane packing as in_data.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: on any edge with rst=1, every stage valid bit, stage data register, stage desc register, out_valid, out_data and out_desc are cleared to 0. in_ready is combinational and equals 1 while the pipeline is empty.
- Reset mid-operation: all in-flight vectors are discarded and never emitted. The first vector after reset can be accepted on the first edge with rst=0.
- Pipeline structure: M stages, S0..S(M-1), each registered. Stage k holds valid_k, desc_k and data_k.
- Compare-exchange lanes:
  - Even k compares lane pairs (0,1),(2,3),…,(M-2,M-1).
  - Odd k compares (1,2),(3,4),…,(M-3,M-2). Lanes 0 and M-1 pass through unchanged on odd stages.
- Compare-exchange rule, for pair (j,j+1), unsigned compare:
  - Ascending: swap iff lane j > lane j+1.
  - Descending: swap iff lane j < lane j+1.
  - Equal keys never swap.
  - Each stage uses its own registered desc bit.
- Stage input: S0 takes in_data/in_desc. Sk (k>0) takes S(k-1) outputs.
- Outputs: out_data/out_desc/out_valid are driven directly from S(M-1) registers.
- Flow control (global enable):
  - en = !out_valid | out_ready.
  - in_ready = en.
  - When en=1, all stages advance on the edge. valid_0 ← in_valid; valid_k ← valid_(k-1).
  - When en=0, all stages hold, and in_valid is ignored.
  - A bubble (valid=0) advances like data. Data registers may update freely while their valid bit is 0.
- Latency: a vector accepted at edge E (in_valid & in_ready) is on out_data with out_valid=1 after edge E+M-1 if no stall occurs. Each stall cycle adds one.
- Throughput: 1 vector/clock with out_ready held high.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_desc are stable.
- Ordering: vectors leave in acceptance order. The direction can change per vector with no penalty or flush.
- Correctness: M stages of odd-even transposition fully sort any M-key vector. Output is a permutation of the input keys with no key lost or duplicated.
- Structure: no combinational path from in_valid/in_data to outputs. The only combinational path from out_ready is to in_ready.

Test Plan:
- Reset then idle, M=4 N=8 → out_valid=0, out_data=0, in_ready=1. Assert rst for 1 cycle mid-stream with 3 vectors in flight → none of them appear.
- Ascending: in_data lanes {0:0x40,1:0x10,2:0xFF,3:0x10}, desc=0, out_ready=1 → exactly 4 cycles later out lanes {0x10,0x10,0x40,0xFF}, out_desc=0.
- Descending, same keys, desc=1 → out lanes {0xFF,0x40,0x10,0x10}.
- Back-to-back: 20 consecutive random vectors with alternating desc, out_ready=1 → 20 outputs on consecutive cycles, in order, each matching a reference sort for its own direction.
- Backpressure: stream 6 vectors, drop out_ready for 3 cycles when the first one is valid → in_ready=0 for those 3 cycles, out_data held constant, no vector lost or duplicated, total latency of the first vector = 4+3.
- Parameter sweep: M=2,N=1 and M=8,N=16 with boundaries (all-equal, already sorted, reverse sorted, all 0x0000/0xFFFF) → every output sorted in its direction and a permutation of its input.
